register_write: RTL and testbench

Architectural register storage and write port for the RV32I integer register file. It holds x1..x31 as 32-bit flops and exposes each one as a named 32-bit output that feeds the register-read multiplexers directly. It accepts one writeback per cycle and keeps a busy scoreboard so decode can detect read-after-write hazards. x0 is not stored; the read side supplies constant zero for it.

---
 rtl/register_write.sv | 130 +++++++++++++
 tb/tb_register_write.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/register_write.sv
// register_write: RV32I architectural register storage (x1..x31) with a
// single writeback port and a busy scoreboard for RAW hazard detection.
// x0 is not stored; the read side supplies zero for it.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   we, rd, wd          writeback enable, destination index, data
//   issue, issue_rd     issued producer and its destination index
//   busy                scoreboard, busy[i]=1 while xi has a pending write
//   ra .. t6            flop outputs for x1..x31 in ABI order
module register_write #(
    parameter logic [31:0]    SP_RESET = 32'h0000_3FFC,
    parameter logic [31:0]    GP_RESET = 32'h0000_1800,
    localparam int unsigned   XLEN     = 32,
    localparam int unsigned   NREG     = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [4:0]      rd,
    input  logic [XLEN-1:0] wd,
    input  logic            issue,
    input  logic [4:0]      issue_rd,
    output logic [NREG-1:0] busy,
    output logic [XLEN-1:0] ra,
    output logic [XLEN-1:0] sp,
    output logic [XLEN-1:0] gp,
    output logic [XLEN-1:0] tp,
    output logic [XLEN-1:0] t0,
    output logic [XLEN-1:0] t1,
    output logic [XLEN-1:0] t2,
    output logic [XLEN-1:0] s0,
    output logic [XLEN-1:0] s1,
    output logic [XLEN-1:0] a0,
    output logic [XLEN-1:0] a1,
    output logic [XLEN-1:0] a2,
    output logic [XLEN-1:0] a3,
    output logic [XLEN-1:0] a4,
    output logic [XLEN-1:0] a5,
    output logic [XLEN-1:0] a6,
    output logic [XLEN-1:0] a7,
    output logic [XLEN-1:0] s2,
    output logic [XLEN-1:0] s3,
    output logic [XLEN-1:0] s4,
    output logic [XLEN-1:0] s5,
    output logic [XLEN-1:0] s6,
    output logic [XLEN-1:0] s7,
    output logic [XLEN-1:0] s8,
    output logic [XLEN-1:0] s9,
    output logic [XLEN-1:0] s10,
    output logic [XLEN-1:0] s11,
    output logic [XLEN-1:0] t3,
    output logic [XLEN-1:0] t4,
    output logic [XLEN-1:0] t5,
    output logic [XLEN-1:0] t6
);

    logic [XLEN-1:0] r_x [1:NREG-1];
    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_wr_dec;
    logic [NREG-1:0] w_set_dec;

    // One-hot decodes; entry 0 dropped so x0 writes and x0 issues do nothing.
    always_comb begin
        w_wr_dec  = '0;
        w_set_dec = '0;
        if (we)    w_wr_dec[rd]        = 1'b1;
        if (issue) w_set_dec[issue_rd] = 1'b1;
        w_wr_dec[0]  = 1'b0;
        w_set_dec[0] = 1'b0;
    end

    // Register storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < int'(NREG); i++) begin
                r_x[i] <= '0;
            end
            r_x[2] <= SP_RESET;
            r_x[3] <= GP_RESET;
        end else begin
            for (int i = 1; i < int'(NREG); i++) begin
                if (w_wr_dec[i]) r_x[i] <= wd;
            end
        end
    end

    // Scoreboard: a new producer (set) overrides a completing one (clear).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_wr_dec) | w_set_dec;
        end
    end

    assign busy = r_busy;
    assign ra   = r_x[1];
    assign sp   = r_x[2];
    assign gp   = r_x[3];
    assign tp   = r_x[4];
    assign t0   = r_x[5];
    assign t1   = r_x[6];
    assign t2   = r_x[7];
    assign s0   = r_x[8];
    assign s1   = r_x[9];
    assign a0   = r_x[10];
    assign a1   = r_x[11];
    assign a2   = r_x[12];
    assign a3   = r_x[13];
    assign a4   = r_x[14];
    assign a5   = r_x[15];
    assign a6   = r_x[16];
    assign a7   = r_x[17];
    assign s2   = r_x[18];
    assign s3   = r_x[19];
    assign s4   = r_x[20];
    assign s5   = r_x[21];
    assign s6   = r_x[22];
    assign s7   = r_x[23];
    assign s8   = r_x[24];
    assign s9   = r_x[25];
    assign s10  = r_x[26];
    assign s11  = r_x[27];
    assign t3   = r_x[28];
    assign t4   = r_x[29];
    assign t5   = r_x[30];
    assign t6   = r_x[31];

endmodule

// File: tb/tb_register_write.sv
// tb_register_write: directed self-checking bench for register_write.
module tb_register_write;

    localparam logic [31:0] SP_RST = 32'h0000_3FFC;
    localparam logic [31:0] GP_RST = 32'h0000_1800;

    logic        clk;
    logic        clk_run;
    logic        rst;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        issue;
    logic [4:0]  issue_rd;
    logic [31:0] busy;
    logic [31:0] ra, sp, gp, tp, t0, t1, t2, s0, s1;
    logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7;
    logic [31:0] s2, s3, s4, s5, s6, s7, s8, s9, s10, s11;
    logic [31:0] t3, t4, t5, t6;

    logic [31:0] x_out [32];
    logic [31:0] exp_x [32];

    int n_cmp;
    int n_bad;

    register_write #(.SP_RESET(SP_RST), .GP_RESET(GP_RST)) dut (
        .clk(clk), .rst(rst), .we(we), .rd(rd), .wd(wd),
        .issue(issue), .issue_rd(issue_rd), .busy(busy),
        .ra(ra), .sp(sp), .gp(gp), .tp(tp), .t0(t0), .t1(t1), .t2(t2),
        .s0(s0), .s1(s1), .a0(a0), .a1(a1), .a2(a2), .a3(a3), .a4(a4),
        .a5(a5), .a6(a6), .a7(a7), .s2(s2), .s3(s3), .s4(s4), .s5(s5),
        .s6(s6), .s7(s7), .s8(s8), .s9(s9), .s10(s10), .s11(s11),
        .t3(t3), .t4(t4), .t5(t5), .t6(t6)
    );

    assign x_out[0]  = '0;
    assign x_out[1]  = ra;
    assign x_out[2]  = sp;
    assign x_out[3]  = gp;
    assign x_out[4]  = tp;
    assign x_out[5]  = t0;
    assign x_out[6]  = t1;
    assign x_out[7]  = t2;
    assign x_out[8]  = s0;
    assign x_out[9]  = s1;
    assign x_out[10] = a0;
    assign x_out[11] = a1;
    assign x_out[12] = a2;
    assign x_out[13] = a3;
    assign x_out[14] = a4;
    assign x_out[15] = a5;
    assign x_out[16] = a6;
    assign x_out[17] = a7;
    assign x_out[18] = s2;
    assign x_out[19] = s3;
    assign x_out[20] = s4;
    assign x_out[21] = s5;
    assign x_out[22] = s6;
    assign x_out[23] = s7;
    assign x_out[24] = s8;
    assign x_out[25] = s9;
    assign x_out[26] = s10;
    assign x_out[27] = s11;
    assign x_out[28] = t3;
    assign x_out[29] = t4;
    assign x_out[30] = t5;
    assign x_out[31] = t6;

    // Gated clock so reset can be exercised with the clock stopped.
    initial clk = 1'b0;
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, expv);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 1; i < 32; i++) begin
            check($sformatf("%s_x%0d", tag, i), x_out[i], exp_x[i]);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; rd = '0; wd = '0; issue = 1'b0; issue_rd = '0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        clk_run = 1'b0;
        rst = 1'b0;
        idle();

        // Reset with the clock stopped takes effect immediately.
        #3 rst = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) exp_x[i] = '0;
        exp_x[2] = 32'h0000_3FFC;
        exp_x[3] = 32'h0000_1800;
        check_regs("rst");
        check("rst_busy", busy, 32'h0);
        #5 rst = 1'b0;
        #2 clk_run = 1'b1;

        // Basic write to a0.
        we = 1'b1; rd = 5'd10; wd = 32'hDEAD_BEEF;
        cyc();
        idle();
        check("a0_write", a0, 32'hDEAD_BEEF);
        exp_x[10] = 32'hDEAD_BEEF;
        check_regs("a0_others");

        // Sweep every register, back to back.
        for (int i = 1; i < 32; i++) begin
            we = 1'b1; rd = 5'(i); wd = 32'(i) * 32'h0101_0101;
            cyc();
        end
        idle();
        for (int i = 1; i < 32; i++) exp_x[i] = 32'(i) * 32'h0101_0101;
        check_regs("sweep");
        check("sweep_t6", t6, 32'h1F1F_1F1F);
        check("sweep_busy", busy, 32'h0);

        // x0 writeback is a NOP.
        we = 1'b1; rd = 5'd0; wd = 32'hFFFF_FFFF;
        cyc();
        idle();
        check_regs("x0wr");
        check("x0wr_busy", busy, 32'h0);

        // Scoreboard set, hold, clear.
        issue = 1'b1; issue_rd = 5'd5;
        cyc();
        idle();
        check("sb_set", busy, 32'h0000_0020);
        for (int k = 0; k < 3; k++) begin
            cyc();
            check($sformatf("sb_hold%0d", k), busy, 32'h0000_0020);
        end
        we = 1'b1; rd = 5'd5; wd = 32'hCAFE_0005;
        cyc();
        idle();
        check("sb_clr", busy, 32'h0);
        check("sb_t0", t0, 32'hCAFE_0005);

        // Collision on x7: set wins, data still written.
        issue = 1'b1; issue_rd = 5'd7;
        cyc();
        check("col_pre", busy, 32'h0000_0080);
        we = 1'b1; rd = 5'd7; wd = 32'h0000_1234;
        cyc();
        idle();
        check("col_t2", t2, 32'h0000_1234);
        check("col_busy", busy, 32'h0000_0080);

        // Clear x7 and set x9 in the same cycle.
        we = 1'b1; rd = 5'd7; wd = 32'h0000_0777;
        issue = 1'b1; issue_rd = 5'd9;
        cyc();
        idle();
        check("diff_busy", busy, 32'h0000_0200);
        check("diff_t2", t2, 32'h0000_0777);

        // issue to x0 is ignored.
        issue = 1'b1; issue_rd = 5'd0;
        cyc();
        idle();
        check("x0iss_busy", busy, 32'h0000_0200);

        // Reset during activity: writes to s5, issues to a3.
        we = 1'b1; rd = 5'd21; wd = 32'hAAAA_0001;
        issue = 1'b1; issue_rd = 5'd13;
        cyc();
        check("act_s5", s5, 32'hAAAA_0001);
        check("act_busy", busy, 32'h0000_2200);
        wd = 32'hAAAA_0002;
        cyc();
        check("act_s5b", s5, 32'hAAAA_0002);
        #2 rst = 1'b1;
        #1;
        check("arst_s5", s5, 32'h0);
        check("arst_busy", busy, 32'h0);
        check("arst_sp", sp, 32'h0000_3FFC);
        check("arst_gp", gp, 32'h0000_1800);
        check("arst_a0", a0, 32'h0);
        // Edge while reset held: write is lost.
        wd = 32'hAAAA_0003;
        cyc();
        check("rsthold_s5", s5, 32'h0);
        check("rsthold_busy", busy, 32'h0);
        #2 rst = 1'b0;
        idle();
        we = 1'b1; rd = 5'd21; wd = 32'h55AA_55AA;
        cyc();
        idle();
        check("post_s5", s5, 32'h55AA_55AA);
        check("post_busy", busy, 32'h0);
        check("post_a3", a3, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
